// File: rtl/conc_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conc_trace_pkg
// Description : Shared types and default sizes for the concolic trace recorder.
// Revision    : 1.0
// ============================================================================
package conc_trace_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REC  = 1'b1
    } trace_state_t;

    localparam int TRACE_DATA_W = 6;
    localparam int TRACE_DEPTH  = 16;
    localparam int TRACE_CYC_W  = 16;

    typedef struct packed {
        logic [TRACE_CYC_W-1:0]  stamp;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/conc_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conc_trace_fifo
// Description : First-word-fall-through trace FIFO; a push into a full FIFO
//               succeeds only when a pop happens in the same cycle.
// Revision    : 1.0
// ============================================================================
module conc_trace_fifo
    import conc_trace_pkg::*;
#(
    parameter int W     = $bits(trace_entry_t),
    parameter int DEPTH = TRACE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

endmodule
`default_nettype wire

// File: rtl/conc_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module      : conc_trace_recorder
// Description : Samples a DUT output vector each recording cycle into a
//               timestamped FWFT trace buffer drained over valid/ready.
//               Optional macro CONC_TRACE_CHANGE_ONLY_EN: capture only on the
//               first cycle or when the sample differs from the last capture.
// Revision    : 1.0
// ============================================================================
module conc_trace_recorder
    import conc_trace_pkg::*;
#(
    parameter int DATA_W = TRACE_DATA_W,
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int CYC_W  = TRACE_CYC_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [DATA_W-1:0]         sample_in,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [CYC_W-1:0]          rd_stamp,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      recording
);

    trace_state_t              r_state;
    logic [CYC_W-1:0]          r_cyc;
    logic                      r_overflow;
    logic                      w_cap;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [CYC_W+DATA_W-1:0]   w_head;

`ifdef CONC_TRACE_CHANGE_ONLY_EN
    logic [DATA_W-1:0]         r_last;
    logic                      r_first;

    assign w_cap = (r_state == REC) && (r_first || (sample_in != r_last));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last  <= '0;
            r_first <= 1'b1;
        end else if (r_state == IDLE && start && !stop) begin
            r_first <= 1'b1;
        end else if (w_cap) begin
            r_last  <= sample_in;
            r_first <= 1'b0;
        end
    end
`else
    assign w_cap = (r_state == REC);
`endif

    assign w_pop = !w_empty && rd_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cyc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            // A drop happens only when full and no read frees a slot this cycle.
            if (w_cap && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_state    <= REC;
                        r_cyc      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                REC: begin
                    if (r_cyc != '1) begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                    if (stop) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    conc_trace_fifo #(
        .W     (CYC_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_cap),
        .i_data  ({r_cyc, sample_in}),
        .i_pop   (rd_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count)
    );

    assign rd_valid  = !w_empty;
    assign rd_data   = w_head[DATA_W-1:0];
    assign rd_stamp  = w_head[CYC_W+DATA_W-1:DATA_W];
    assign overflow  = r_overflow;
    assign recording = (r_state == REC);

endmodule
`default_nettype wire

// File: tb/tb_conc_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conc_trace_recorder
// Description : Self-checking bench for conc_trace_recorder (default sizes plus
//               a 4-bit-stamp instance for saturation).
// Revision    : 1.0
// ============================================================================
module tb_conc_trace_recorder;

    localparam int DW    = 6;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, stop = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          rd_valid, overflow, recording;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] rd_stamp;
    logic [4:0]    count;

    logic          s_start = 1'b0, s_stop = 1'b0, s_rd_ready = 1'b0;
    logic [DW-1:0] s_sample = '0;
    logic          s_rd_valid, s_overflow, s_recording;
    logic [DW-1:0] s_rd_data;
    logic [3:0]    s_rd_stamp;
    logic [4:0]    s_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [CW-1:0] stamp;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          st;
        logic          sp;
        logic [DW-1:0] smp;
        logic          rr;
        int            ecount;
        logic [DW-1:0] edata;
        logic [CW-1:0] estamp;
    } vec_t;

    ent_t          mq[$];
    logic          m_rec, m_ovf, m_first;
    logic [CW-1:0] m_cyc;
    logic [DW-1:0] m_last;

    conc_trace_recorder #(.DATA_W(DW), .DEPTH(DEPTH), .CYC_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .sample_in(sample_in), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_stamp(rd_stamp), .count(count),
        .overflow(overflow), .recording(recording)
    );

    conc_trace_recorder #(.DATA_W(DW), .DEPTH(DEPTH), .CYC_W(4)) dut_sat (
        .clock(clock), .reset(reset), .start(s_start), .stop(s_stop),
        .sample_in(s_sample), .rd_ready(s_rd_ready), .rd_valid(s_rd_valid),
        .rd_data(s_rd_data), .rd_stamp(s_rd_stamp), .count(s_count),
        .overflow(s_overflow), .recording(s_recording)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rec = 1'b0; m_ovf = 1'b0; m_first = 1'b1; m_cyc = '0; m_last = '0;
    endtask

    // Called just after a negedge: drive, compare against the model, advance it.
    task automatic step(input logic st, input logic sp, input logic [DW-1:0] smp, input logic rr);
        logic pop, cap;
        start = st; stop = sp; sample_in = smp; rd_ready = rr;
        #1;
        chk("count", 32'(count), 32'(mq.size()));
        chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("recording", 32'(recording), 32'(m_rec));
        if (mq.size() != 0) begin
            chk("rd_data", 32'(rd_data), 32'(mq[0].data));
            chk("rd_stamp", 32'(rd_stamp), 32'(mq[0].stamp));
        end
        pop = rr && (mq.size() != 0);
        cap = m_rec;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
        cap = m_rec && (m_first || smp != m_last);
`endif
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (mq.size() < DEPTH) mq.push_back('{stamp: m_cyc, data: smp});
            else m_ovf = 1'b1;
            m_last = smp; m_first = 1'b0;
        end
        if (m_rec) begin
            if (m_cyc != '1) m_cyc = m_cyc + 1'b1;
            if (sp) m_rec = 1'b0;
        end else if (st && !sp) begin
            m_rec = 1'b1; m_cyc = '0; m_first = 1'b1; m_ovf = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [15:0] sq[$];
        logic [15:0] e;

        model_reset();
        #2;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rec", 32'(recording), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_stamp", 32'(rd_stamp), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Expected count/head seen before each row's clock edge.
`ifdef CONC_TRACE_CHANGE_ONLY_EN
        tbl.push_back('{1, 0, 6'h00, 1, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h01, 1, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h01, 1, 1, 6'h01, 16'd0});
        tbl.push_back('{0, 0, 6'h01, 1, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h2A, 1, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h2A, 1, 1, 6'h2A, 16'd3});
        tbl.push_back('{0, 1, 6'h05, 1, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h00, 1, 1, 6'h05, 16'd5});
        tbl.push_back('{0, 0, 6'h00, 1, 0, 6'h00, 16'd0});
`else
        tbl.push_back('{1, 0, 6'h00, 0, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h3F, 0, 0, 6'h00, 16'd0});
        tbl.push_back('{0, 0, 6'h3F, 0, 1, 6'h3F, 16'd0});
        tbl.push_back('{0, 0, 6'h3F, 0, 2, 6'h3F, 16'd0});
        tbl.push_back('{0, 1, 6'h3F, 0, 3, 6'h3F, 16'd0});
        tbl.push_back('{0, 0, 6'h00, 0, 4, 6'h3F, 16'd0});
        tbl.push_back('{0, 0, 6'h00, 1, 4, 6'h3F, 16'd0});
        tbl.push_back('{0, 0, 6'h00, 1, 3, 6'h3F, 16'd1});
        tbl.push_back('{0, 0, 6'h00, 1, 2, 6'h3F, 16'd2});
        tbl.push_back('{0, 0, 6'h00, 1, 1, 6'h3F, 16'd3});
        tbl.push_back('{0, 0, 6'h00, 1, 0, 6'h00, 16'd0});
`endif
        foreach (tbl[i]) begin
            start = tbl[i].st; stop = tbl[i].sp; sample_in = tbl[i].smp; rd_ready = tbl[i].rr;
            #1;
            chk("tbl_count", 32'(count), 32'(tbl[i].ecount));
            chk("tbl_valid", 32'(rd_valid), 32'(tbl[i].ecount != 0));
            if (tbl[i].ecount != 0) begin
                chk("tbl_data", 32'(rd_data), 32'(tbl[i].edata));
                chk("tbl_stamp", 32'(rd_stamp), 32'(tbl[i].estamp));
            end
            step(tbl[i].st, tbl[i].sp, tbl[i].smp, tbl[i].rr);
        end

        // Overflow: 20 distinct samples into a 16-deep buffer with no reads.
        step(1, 0, 6'h00, 0);
        for (int i = 0; i < 20; i++) step(0, i == 19, 6'(i + 1), 0);
        #1;
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head_stamp", 32'(rd_stamp), 32'd0);
        step(1, 0, 6'h07, 0);
        #1;
        chk("restart_ovf", 32'(overflow), 32'd0);
        chk("restart_count", 32'(count), 32'd16);
        step(0, 1, 6'h33, 1);
        #1;
        chk("fullpop_count", 32'(count), 32'd16);
        chk("fullpop_stamp", 32'(rd_stamp), 32'd1);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("drain_stamp", 32'(rd_stamp), (k < 15) ? 32'(k + 1) : 32'd0);
            step(0, 0, 6'h00, 1);
        end
        step(0, 0, 6'h00, 0);

        // Reset while recording with five entries held.
        step(1, 0, 6'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 6'(i + 9), 0);
        #1;
        chk("pre_rst_count", 32'(count), 32'd5);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_rec", 32'(recording), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        step(0, 0, 6'h00, 0);

        // Saturating 4-bit stamps, drained continuously.
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        s_rd_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i < 20) begin
                s_sample = 6'(i);
                s_stop = (i == 19);
                sq.push_back({6'(i), (i > 15) ? 10'd15 : 10'(i)});
            end else begin
                s_stop = 1'b0;
            end
            #1;
            if (s_rd_valid) begin
                if (sq.size() == 0) begin
                    chk("sat_extra", 32'(s_rd_valid), 32'd0);
                end else begin
                    e = sq.pop_front();
                    chk("sat_stamp", 32'(s_rd_stamp), 32'(e[3:0]));
                    chk("sat_data", 32'(s_rd_data), 32'(e[15:10]));
                end
            end
            @(negedge clock);
        end
        chk("sat_drained", 32'(sq.size()), 32'd0);
        chk("sat_ovf", 32'(s_overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
